// File: rtl/io_map_pkg.sv
// Register map and bit layout for the I/O words loaded into the register file.
// Shared by the capture logic and anything decoding r20/r22/r24/r26.
package io_map_pkg;

  localparam int REG_BTN    = 20;
  localparam int REG_SCREEN = 22;
  localparam int REG_COLL   = 24;
  localparam int REG_PAUSE  = 26;

  localparam int BTN_JUMP     = 0;
  localparam int BTN_DUCK     = 1;
  localparam int COLL_FLAG    = 0;
  localparam int COLL_CNT_LSB = 16;

  localparam int HIT_W = 16;

  typedef struct packed {
    logic [HIT_W-1:0] count;
    logic             flag;
  } coll_t;

  function automatic logic [31:0] btn_word(
    input logic jump,
    input logic duck
  );
    logic [31:0] w;
    w           = '0;
    w[BTN_JUMP] = jump;
    w[BTN_DUCK] = duck;
    return w;
  endfunction

  function automatic logic [31:0] coll_word(
    input coll_t c
  );
    logic [31:0] w;
    w                           = '0;
    w[COLL_CNT_LSB +: HIT_W]    = c.count;
    w[COLL_FLAG]                = c.flag;
    return w;
  endfunction

endpackage

// File: rtl/io_event_capture_if.sv
// Register-file side of the I/O capture block: load values and strobes.
// master drives them, slave (the regfile) consumes them.
interface io_event_capture_if;

  logic [31:0] r20;
  logic [31:0] r22;
  logic [31:0] r24;
  logic [31:0] r26;
  logic        button_signal_reg;
  logic        screen_signal_reg;
  logic        collision_signal_reg;
  logic        pause_signal_reg;

  modport master (
    output r20,
    output r22,
    output r24,
    output r26,
    output button_signal_reg,
    output screen_signal_reg,
    output collision_signal_reg,
    output pause_signal_reg
  );

  modport slave (
    input r20,
    input r22,
    input r24,
    input r26,
    input button_signal_reg,
    input screen_signal_reg,
    input collision_signal_reg,
    input pause_signal_reg
  );

endinterface

// File: rtl/io_event_capture_debouncer.sv
// One button: 2-FF synchroniser followed by a stability counter.
// rise/fall are single-cycle flags coinciding with the stable level flipping.
module io_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 20
) (
  input  logic clock,
  input  logic ctrl_reset,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             flip;
  logic [CNT_W-1:0] cnt;

  assign flip = (s2 != stable) && (cnt == LAST);
  assign rise = flip & ~stable;
  assign fall = flip & stable;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_event_capture.sv
// Board inputs to regfile I/O words: debounced buttons, frame counter,
// latched collision with hit count, and pause toggle, each with a load strobe.
module io_event_capture
  import io_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FRAME_DIV       = 833333,
  parameter int CNT_W           = 20
) (
  input  logic               clock,
  input  logic               ctrl_reset,
  input  logic               btn_jump_raw,
  input  logic               btn_duck_raw,
  input  logic               btn_pause_raw,
  input  logic               collision_in,
  input  logic               collision_clear,
  io_event_capture_if.master regs
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(FRAME_DIV - 1);

  logic jump;
  logic duck;
  logic pstab;
  logic jump_rise;
  logic jump_fall;
  logic duck_rise;
  logic duck_fall;
  logic pause_rise;
  logic pause_fall;

  logic [CNT_W-1:0] div;
  logic [31:0]      frame;
  logic             paused;
  coll_t            coll;
  logic             c1;
  logic             c2;
  logic             c3;

  logic btn_stb;
  logic scr_stb;
  logic col_stb;
  logic pau_stb;

  logic tick;
  logic pause_evt;
  logic hit_edge;
  logic set_ev;
  logic clr_ev;

  io_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_jump (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .raw       (btn_jump_raw),
    .stable    (jump),
    .rise      (jump_rise),
    .fall      (jump_fall)
  );

  io_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_duck (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .raw       (btn_duck_raw),
    .stable    (duck),
    .rise      (duck_rise),
    .fall      (duck_fall)
  );

  io_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_pause (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .raw       (btn_pause_raw),
    .stable    (pstab),
    .rise      (pause_rise),
    .fall      (pause_fall)
  );

  assign tick      = (div == DIV_LAST);
  assign pause_evt = pause_rise & ~(pause_fall | pstab);
  assign hit_edge  = c2 & ~c3;

  // a fresh edge arriving with an acknowledge re-arms immediately
  assign set_ev = hit_edge & ~paused
                & (~coll.flag | collision_clear);
  assign clr_ev = collision_clear & coll.flag & ~set_ev;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      btn_stb <= 1'b0;
    end else begin
      btn_stb <= jump_rise | jump_fall
               | duck_rise | duck_fall;
    end
  end

  // divider free-runs through pause; only the count is gated
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      div     <= '0;
      frame   <= '0;
      scr_stb <= 1'b0;
    end else begin
      scr_stb <= tick & ~paused;
      if (tick) begin
        div <= '0;
      end else begin
        div <= div + CNT_W'(1);
      end
      if (tick && !paused) begin
        frame <= frame + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      paused  <= 1'b0;
      pau_stb <= 1'b0;
    end else begin
      pau_stb <= pause_evt;
      if (pause_evt) begin
        paused <= ~paused;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      c1      <= 1'b0;
      c2      <= 1'b0;
      c3      <= 1'b0;
      coll    <= '0;
      col_stb <= 1'b0;
    end else begin
      c1      <= collision_in;
      c2      <= c1;
      c3      <= c2;
      col_stb <= set_ev | clr_ev;
      if (set_ev) begin
        coll.flag <= 1'b1;
        if (coll.count != '1) begin
          coll.count <= coll.count + HIT_W'(1);
        end
      end else if (clr_ev) begin
        coll.flag <= 1'b0;
      end
    end
  end

  assign regs.r20                  = btn_word(jump, duck);
  assign regs.r22                  = frame;
  assign regs.r24                  = coll_word(coll);
  assign regs.r26                  = {31'b0, paused};
  assign regs.button_signal_reg    = btn_stb;
  assign regs.screen_signal_reg    = scr_stb;
  assign regs.collision_signal_reg = col_stb;
  assign regs.pause_signal_reg     = pau_stb;

endmodule

// File: tb/tb_io_event_capture.sv
// Scoreboard bench for io_event_capture: per-cycle expected outputs from a
// queue-based reference model, plus directed checks of the key scenarios.
module tb_io_event_capture;

  localparam int DEB  = 4;
  localparam int FDIV = 10;

  typedef struct packed {
    logic [31:0] r20;
    logic [31:0] r22;
    logic [31:0] r24;
    logic [31:0] r26;
    logic        bs;
    logic        ss;
    logic        cs;
    logic        ps;
  } exp_t;

  logic clk;
  logic rst;
  logic j;
  logic d;
  logic p;
  logic c;
  logic cl;

  io_event_capture_if io();

  io_event_capture #(
    .DEBOUNCE_CYCLES(DEB),
    .FRAME_DIV      (FDIV),
    .CNT_W          (20)
  ) dut (
    .clock          (clk),
    .ctrl_reset     (rst),
    .btn_jump_raw   (j),
    .btn_duck_raw   (d),
    .btn_pause_raw  (p),
    .collision_in   (c),
    .collision_clear(cl),
    .regs           (io)
  );

  int total = 0;
  int bad   = 0;
  int n_bs  = 0;
  int n_ss  = 0;
  int n_cs  = 0;
  int n_ps  = 0;

  exp_t sbq[$];
  exp_t got;

  // reference model state
  bit          jq[$];
  bit          dq[$];
  bit          pq[$];
  bit          cq[$];
  bit          st[3];
  int          run[3];
  bit          paused;
  bit          hit;
  int          hits;
  logic [31:0] frames;
  int          since;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  function automatic void reset_model();
    jq = '{0, 0};
    dq = '{0, 0};
    pq = '{0, 0};
    cq = '{0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      st[i]  = 0;
      run[i] = 0;
    end
    paused = 0;
    hit    = 0;
    hits   = 0;
    frames = 0;
    since  = 0;
  endfunction

  // a level is accepted after DEB consecutive synced samples that differ
  function automatic bit deb(input int b, input bit s);
    if (s == st[b]) begin
      run[b] = 0;
      return 0;
    end
    run[b]++;
    if (run[b] < DEB) return 0;
    run[b] = 0;
    st[b]  = ~st[b];
    return 1;
  endfunction

  function automatic void model(input bit rs, input bit mj,
                                input bit md, input bit mp,
                                input bit mc, input bit mcl);
    exp_t e;
    bit sj, sd, sp, cc, cp;
    bit chj, chd, chp, edg, set_e, clr_e;
    e = '0;
    if (rs) begin
      reset_model();
    end else begin
      sj = jq.pop_front();
      jq.push_back(mj);
      sd = dq.pop_front();
      dq.push_back(md);
      sp = pq.pop_front();
      pq.push_back(mp);
      cp = cq[0];
      cc = cq[1];
      void'(cq.pop_front());
      cq.push_back(mc);
      chj = deb(0, sj);
      chd = deb(1, sd);
      chp = deb(2, sp);
      since++;
      e.ss = ((since % FDIV) == 0) && !paused;
      if (e.ss) frames = frames + 32'd1;
      edg   = cc && !cp;
      set_e = edg && !paused && (!hit || mcl);
      clr_e = mcl && hit && !set_e;
      if (set_e) begin
        hit = 1;
        if (hits < 65535) hits++;
      end else if (clr_e) begin
        hit = 0;
      end
      e.cs = set_e || clr_e;
      e.ps = chp && st[2];
      if (e.ps) paused = !paused;
      e.bs  = chj || chd;
      e.r20 = {30'b0, st[1], st[0]};
      e.r22 = frames;
      e.r24 = {hits[15:0], 15'b0, hit};
      e.r26 = {31'b0, paused};
    end
    sbq.push_back(e);
  endfunction

  // one clock: expected response for the coming edge is queued first
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model(rst, j, d, p, c, cl);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      got = sbq.pop_front();
      chk("cyc r20", io.r20, got.r20);
      chk("cyc r22", io.r22, got.r22);
      chk("cyc r24", io.r24, got.r24);
      chk("cyc r26", io.r26, got.r26);
      chk("cyc btn_stb", 32'(io.button_signal_reg), 32'(got.bs));
      chk("cyc scr_stb", 32'(io.screen_signal_reg), 32'(got.ss));
      chk("cyc col_stb", 32'(io.collision_signal_reg), 32'(got.cs));
      chk("cyc pau_stb", 32'(io.pause_signal_reg), 32'(got.ps));
      n_bs += int'(io.button_signal_reg);
      n_ss += int'(io.screen_signal_reg);
      n_cs += int'(io.collision_signal_reg);
      n_ps += int'(io.pause_signal_reg);
    end
  end

  initial begin
    int b0, s0, c0, p0;
    rst = 1; j = 0; d = 0; p = 0; c = 0; cl = 0;
    reset_model();
    step(2);
    settle();
    chk("reset r20", io.r20, 32'h0);
    chk("reset r22", io.r22, 32'h0);
    chk("reset r24", io.r24, 32'h0);
    chk("reset r26", io.r26, 32'h0);
    rst = 0;

    b0 = n_bs;
    j = 1; step(3);
    j = 0; step(10);
    settle();
    chk("short jump strobes", n_bs - b0, 0);
    chk("short jump r20", io.r20, 32'h0);
    j = 1; step(8);
    settle();
    chk("held jump strobes", n_bs - b0, 1);
    chk("held jump r20", io.r20, 32'h1);
    j = 0; step(8);
    settle();
    chk("jump release r20", io.r20, 32'h0);

    b0 = n_bs;
    j = 1; d = 1; step(8);
    settle();
    chk("dual press strobes", n_bs - b0, 1);
    chk("dual press r20", io.r20, 32'h3);
    j = 0; d = 0; step(8);
    settle();
    chk("dual release strobes", n_bs - b0, 2);
    chk("dual release r20", io.r20, 32'h0);

    rst = 1; step(1);
    rst = 0;
    s0 = n_ss;
    step(30);
    settle();
    chk("free run frames", n_ss - s0, 3);
    chk("free run r22", io.r22, 32'd3);
    p0 = n_ps;
    p = 1; step(8);
    settle();
    chk("pause strobe", n_ps - p0, 1);
    chk("pause r26", io.r26, 32'h1);
    s0 = n_ss;
    p = 0; step(50);
    settle();
    chk("paused frames", n_ss - s0, 0);
    p = 1; step(8);
    settle();
    chk("unpause r26", io.r26, 32'h0);
    step(8);
    settle();
    chk("resume r22", io.r22, 32'd4);
    chk("resume frames", n_ss - s0, 1);
    p = 0; step(8);

    c0 = n_cs;
    c = 1; step(20);
    settle();
    chk("hit strobes", n_cs - c0, 1);
    chk("hit r24", io.r24, 32'h0001_0001);
    cl = 1; step(1);
    cl = 0; step(2);
    settle();
    chk("clear strobes", n_cs - c0, 2);
    chk("clear r24", io.r24, 32'h0001_0000);
    c = 0; step(4);
    c = 1; step(2);
    cl = 1; step(1);
    cl = 0; step(2);
    settle();
    chk("edge+clr strobes", n_cs - c0, 3);
    chk("edge+clr r24", io.r24, 32'h0002_0001);
    c = 0; step(4);
    c = 1; step(2);
    cl = 1; step(1);
    cl = 0; step(2);
    settle();
    chk("set wins strobes", n_cs - c0, 4);
    chk("set wins r24", io.r24, 32'h0003_0001);
    c = 0; step(4);

    j = 1; step(4);
    j = 0; rst = 1; step(1);
    settle();
    chk("mid reset r20", io.r20, 32'h0);
    chk("mid reset r22", io.r22, 32'h0);
    chk("mid reset r24", io.r24, 32'h0);
    chk("mid reset r26", io.r26, 32'h0);
    rst = 0;
    b0 = n_bs; s0 = n_ss; c0 = n_cs; p0 = n_ps;
    step(3);
    settle();
    chk("post reset strobes",
        (n_bs - b0) + (n_ss - s0) + (n_cs - c0) + (n_ps - p0), 0);
    chk("post reset r20", io.r20, 32'h0);

    rst = 1; step(1);
    rst = 0; step(4);
    j = 1; step(3);
    c = 1; step(3);
    settle();
    chk("joint btn_stb", 32'(io.button_signal_reg), 32'h1);
    chk("joint scr_stb", 32'(io.screen_signal_reg), 32'h1);
    chk("joint col_stb", 32'(io.collision_signal_reg), 32'h1);
    chk("joint r20", io.r20, 32'h1);
    chk("joint r22", io.r22, 32'h1);
    chk("joint r24", io.r24, 32'h0001_0001);
    j = 0; c = 0; step(8);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 7) == 0) j = ~j;
      if ($urandom_range(0, 7) == 0) d = ~d;
      if ($urandom_range(0, 29) == 0) p = ~p;
      if ($urandom_range(0, 5) == 0) c = ~c;
      cl = ($urandom_range(0, 7) == 0);
      step(1);
    end
    rst = 0; j = 0; d = 0; p = 0; c = 0; cl = 0;
    step(10);
    settle();
    settle();
    chk("scoreboard drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
